sram_port_arbiter: RTL and testbench

//   Shares the single external asynchronous SRAM bus between two on-chip requesters.

---
 rtl/sram_pkg.sv | 28 ++
 rtl/sram_port_arbiter_if.sv | 36 +++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/sram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// ============================================================================
// Package     : sram_pkg
// Description : Shared types and constants for the SRAM port arbiter
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    // Default external SRAM geometry (word address / data widths)
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    // Requester identifiers used by the round-robin pointer and owner register
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_port_arbiter_if.sv
// ============================================================================
// Interface   : sram_port_arbiter_if
// Description : Requester-side handshake bundle (port A read/write, port B read)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_port_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              aReq;
    logic              aWe;
    logic [ADDR_W-1:0] aAddr;
    logic [DATA_W-1:0] aWdata;
    logic [DATA_W-1:0] aRdata;
    logic              aDone;
    logic              bReq;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] bRdata;
    logic              bDone;

    // Requester side
    modport master (
        output aReq, aWe, aAddr, aWdata, bReq, bAddr,
        input  aRdata, aDone, bRdata, bDone
    );

    // Arbiter side
    modport slave (
        input  aReq, aWe, aAddr, aWdata, bReq, bAddr,
        output aRdata, aDone, bRdata, bDone
    );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin pick; owns the last-grant pointer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import sram_pkg::*;
(
    input  wire  clk,
    input  wire  rst,        // asynchronous, active-low
    input  wire  a_req_i,
    input  wire  b_req_i,
    input  wire  take_i,     // the sequencer accepts the current pick this cycle
    output logic valid_o,
    output logic winner_o
);

    logic last_q;

    // Combinational pick: a lone requester wins outright, a tie goes to the port not granted last
    always_comb begin
        valid_o  = a_req_i | b_req_i;
        winner_o = PORT_A;
        if (a_req_i && b_req_i) begin
            winner_o = (last_q == PORT_A) ? PORT_B : PORT_A;
        end else if (b_req_i) begin
            winner_o = PORT_B;
        end
    end

    // Pointer moves only on an accepted grant; reset value makes A win the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_B;
        end else if (take_i && valid_o) begin
            last_q <= winner_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module      : sram_port_arbiter
// Description : Shares one asynchronous SRAM bus between port A (R/W) and
//               port B (read-only) with fixed setup/strobe/hold sequencing
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1            // strobe length, 1..7
) (
    input  wire                clk,
    input  wire                rst,          // asynchronous, active-low
    sram_port_arbiter_if.slave req_if,
    inout  wire  [DATA_W-1:0]  memDataBus,
    output logic [ADDR_W-1:0]  memAddrBus,
    output logic               memRead,
    output logic               memWrite,
    output logic               memEnable
);

    localparam logic [2:0] LAST_WAIT = 3'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
    logic              take;
    logic              arb_valid;
    logic              arb_winner;
    logic              capture;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .rst      (rst),
        .a_req_i  (req_if.aReq),
        .b_req_i  (req_if.bReq),
        .take_i   (take),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

    // Next-state logic for the setup/strobe/hold sequence and the strobe counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    take    = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = 3'd0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q == LAST_WAIT) begin
                    cnt_d   = 3'd0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the winner's request at grant so later input changes cannot disturb the access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= PORT_A;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (take) begin
            owner_q <= arb_winner;
            we_q    <= (arb_winner == PORT_A) && req_if.aWe;
            addr_q  <= (arb_winner == PORT_B) ? req_if.bAddr : req_if.aAddr;
            wdata_q <= req_if.aWdata;
        end
    end

    // Read data is sampled on the edge that ends the strobe
    assign capture = (state_q == ST_ACCESS) && (cnt_q == LAST_WAIT) && !we_q;

    // Per-port read-data holding registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else if (capture) begin
            if (owner_q == PORT_B) begin
                b_rdata_q <= memDataBus;
            end else begin
                a_rdata_q <= memDataBus;
            end
        end
    end

    // Pin and handshake outputs decode straight from registered state
    assign memEnable  = (state_q == ST_IDLE);
    assign memRead    = !((state_q == ST_ACCESS) && !we_q);
    assign memWrite   = !((state_q == ST_ACCESS) && we_q);
    assign memAddrBus = addr_q;
    assign memDataBus = ((state_q != ST_IDLE) && we_q) ? wdata_q : {DATA_W{1'bz}};

    assign req_if.aDone  = (state_q == ST_HOLD) && (owner_q == PORT_A);
    assign req_if.bDone  = (state_q == ST_HOLD) && (owner_q == PORT_B);
    assign req_if.aRdata = a_rdata_q;
    assign req_if.bRdata = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module      : tb_sram_port_arbiter
// Description : Directed bench for sram_port_arbiter (WAIT_CYCLES 1 and 3)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;
    import sram_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_W(18), .DATA_W(16)) if1 ();
    sram_port_arbiter_if #(.ADDR_W(18), .DATA_W(16)) if3 ();

    wire  [15:0] bus1, bus3;
    logic [17:0] addr1, addr3;
    logic        rd1, wr1, ce1, rd3, wr3, ce3;

    sram_port_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_if(if1.slave), .memDataBus(bus1),
        .memAddrBus(addr1), .memRead(rd1), .memWrite(wr1), .memEnable(ce1)
    );

    sram_port_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .req_if(if3.slave), .memDataBus(bus3),
        .memAddrBus(addr3), .memRead(rd3), .memWrite(wr3), .memEnable(ce3)
    );

    // Asynchronous SRAM models: drive on CE&OE, store on the rising edge of WE
    logic [15:0] mem1 [0:255];
    logic [15:0] mem3 [0:255];
    assign bus1 = (!ce1 && !rd1) ? mem1[addr1[7:0]] : 16'hzzzz;
    assign bus3 = (!ce3 && !rd3) ? mem3[addr3[7:0]] : 16'hzzzz;
    always @(posedge wr1) if (!ce1) mem1[addr1[7:0]] = bus1;
    always @(posedge wr3) if (!ce3) mem3[addr3[7:0]] = bus3;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Undriven bus: z in a four-state simulator, 0 in a two-state one
    function automatic logic bus_free(input logic [15:0] v);
        return (v === 16'hzzzz) || (v === 16'h0000);
    endfunction

    // Continuous protocol checks and Done counting
    int   adone1 = 0;
    logic pa1 = 0, pb1 = 0, pa3 = 0, pb3 = 0;
    always @(negedge clk) begin
        if (rst) begin
            chk("excl_done1", {31'd0, if1.aDone & if1.bDone}, 0);
            chk("excl_done3", {31'd0, if3.aDone & if3.bDone}, 0);
            chk("rd_wr1", {31'd0, !rd1 & !wr1}, 0);
            chk("rd_wr3", {31'd0, !rd3 & !wr3}, 0);
            chk("pulse1", {31'd0, (if1.aDone & pa1) | (if1.bDone & pb1)}, 0);
            chk("pulse3", {31'd0, (if3.aDone & pa3) | (if3.bDone & pb3)}, 0);
            if (if1.aDone) adone1++;
            pa1 = if1.aDone; pb1 = if1.bDone; pa3 = if3.aDone; pb3 = if3.bDone;
        end else begin
            pa1 = 0; pb1 = 0; pa3 = 0; pb3 = 0;
        end
    end

    task automatic set_req(input bit inst3, input bit pb, input bit we,
                           input logic [17:0] addr, input logic [15:0] wd);
        if (!inst3) begin
            if (!pb) begin if1.aWe = we; if1.aAddr = addr; if1.aWdata = wd; if1.aReq = 1'b1; end
            else     begin if1.bAddr = addr; if1.bReq = 1'b1; end
        end else begin
            if (!pb) begin if3.aWe = we; if3.aAddr = addr; if3.aWdata = wd; if3.aReq = 1'b1; end
            else     begin if3.bAddr = addr; if3.bReq = 1'b1; end
        end
    endtask

    // Perturb request fields after grant; the latched copy must be used
    task automatic scramble(input bit inst3, input bit pb);
        if (!inst3) begin
            if (!pb) begin if1.aAddr ^= 18'h1; if1.aWdata = ~if1.aWdata; if1.aWe = ~if1.aWe; end
            else     if1.bAddr ^= 18'h1;
        end else begin
            if (!pb) begin if3.aAddr ^= 18'h1; if3.aWdata = ~if3.aWdata; if3.aWe = ~if3.aWe; end
            else     if3.bAddr ^= 18'h1;
        end
    endtask

    task automatic drop_req(input bit inst3, input bit pb);
        if (!inst3) begin if (!pb) if1.aReq = 1'b0; else if1.bReq = 1'b0; end
        else        begin if (!pb) if3.aReq = 1'b0; else if3.bReq = 1'b0; end
    endtask

    // One access from an idle sequencer; edges counted from the request to Done visible
    task automatic xfer(input bit inst3, input bit pb, input bit we, input logic [17:0] addr,
                        input logic [15:0] wd, input int drop_at,
                        output int edges, output int wl, output int rl,
                        output bit bus_ok, output logic [15:0] rd);
        logic done;
        edges = 0; wl = 0; rl = 0; bus_ok = 1'b1; done = 1'b0;
        @(negedge clk);
        set_req(inst3, pb, we, addr, wd);
        while (!done && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!(inst3 ? wr3 : wr1)) wl++;
            if (!(inst3 ? rd3 : rd1)) rl++;
            if (we && !(inst3 ? ce3 : ce1) && ((inst3 ? bus3 : bus1) !== wd)) bus_ok = 1'b0;
            if (edges == 1) scramble(inst3, pb);
            if (edges == drop_at) drop_req(inst3, pb);
            done = pb ? (inst3 ? if3.bDone : if1.bDone) : (inst3 ? if3.aDone : if1.aDone);
        end
        chk("done_seen", {31'd0, done}, 1);
        rd = pb ? (inst3 ? if3.bRdata : if1.bRdata) : (inst3 ? if3.aRdata : if1.aRdata);
        drop_req(inst3, pb);
    endtask

    int          e, wl, rl, got, cyc, last_cyc, n_before;
    bit          ok;
    logic [15:0] rd;
    logic [3:0]  ord;

    initial begin
        rst = 1'b0;
        if1.aReq = 0; if1.aWe = 0; if1.aAddr = '0; if1.aWdata = '0; if1.bReq = 0; if1.bAddr = '0;
        if3.aReq = 0; if3.aWe = 0; if3.aAddr = '0; if3.aWdata = '0; if3.bReq = 0; if3.bAddr = '0;
        for (int i = 0; i < 256; i++) begin mem1[i] = 16'h0; mem3[i] = 16'h0; end
        mem1[8'h20] = 16'hAAAA;
        mem1[8'h21] = 16'hBBBB;

        // 1. Reset with both ports requesting
        if1.aAddr = 18'h00020; if1.aReq = 1'b1;
        if1.bAddr = 18'h00021; if1.bReq = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rd", {31'd0, rd1}, 1);
        chk("rst_wr", {31'd0, wr1}, 1);
        chk("rst_ce", {31'd0, ce1}, 1);
        chk("rst_addr", {14'd0, addr1}, 0);
        chk("rst_bus", {31'd0, bus_free(bus1)}, 1);
        chk("rst_done", {30'd0, if1.aDone, if1.bDone}, 0);
        chk("rst_rdata", {if1.aRdata, if1.bRdata}, 0);
        chk("rst_ce3", {31'd0, ce3}, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("first_grant_addr", {14'd0, addr1}, 32'h20);
        chk("first_grant_ce", {31'd0, ce1}, 0);

        // 4. Contention: four back-to-back grants, alternating from A
        got = 0; cyc = 0; last_cyc = 0; ord = 4'h0;
        while (got < 4 && cyc < 40) begin
            if (if1.aDone || if1.bDone) begin
                ord[got] = if1.bDone;
                chk(if1.bDone ? "cont_brdata" : "cont_ardata",
                    {16'd0, if1.bDone ? if1.bRdata : if1.aRdata},
                    if1.bDone ? 32'hBBBB : 32'hAAAA);
                if (got > 0) chk("cont_spacing", cyc - last_cyc, 4);
                last_cyc = cyc;
                got++;
            end
            if (got < 4) begin @(negedge clk); cyc++; end
        end
        if1.aReq = 1'b0; if1.bReq = 1'b0;
        chk("cont_count", got, 4);
        chk("cont_order", {28'd0, ord}, 32'hA);

        // 2. Port A write, one-cycle strobe
        xfer(0, 0, 1, 18'h00010, 16'hBEEF, 99, e, wl, rl, ok, rd);
        chk("wr_latency", e, 3);
        chk("wr_strobe", wl, 1);
        chk("wr_no_rd", rl, 0);
        chk("wr_bus", {31'd0, ok}, 1);
        chk("wr_mem", {16'd0, mem1[8'h10]}, 32'hBEEF);

        // 3. Port B read
        mem1[8'h10] = 16'h1234;
        xfer(0, 1, 0, 18'h00010, 16'h0, 99, e, wl, rl, ok, rd);
        chk("rd_latency", e, 3);
        chk("rd_strobe", rl, 1);
        chk("rd_no_wr", wl, 0);
        chk("rd_data", {16'd0, rd}, 32'h1234);

        // 5. Reset during ACCESS of an A write
        @(negedge clk);
        set_req(0, 0, 1, 18'h00030, 16'h5A5A);
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("abort_pre_wr", {31'd0, wr1}, 0);
        n_before = adone1;
        #1 rst = 1'b0;
        #1;
        chk("abort_wr", {31'd0, wr1}, 1);
        chk("abort_ce", {31'd0, ce1}, 1);
        chk("abort_bus", {31'd0, bus_free(bus1)}, 1);
        if1.aReq = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", {31'd0, if1.aDone}, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_done_cnt", adone1 - n_before, 0);
        xfer(0, 0, 0, 18'h00020, 16'h0, 99, e, wl, rl, ok, rd);
        chk("post_abort_latency", e, 3);
        chk("post_abort_data", {16'd0, rd}, 32'hAAAA);

        // 6. WAIT_CYCLES = 3
        mem3[8'h40] = 16'hC3C3;
        xfer(1, 1, 0, 18'h00040, 16'h0, 99, e, wl, rl, ok, rd);
        chk("w3_latency", e, 5);
        chk("w3_rd_strobe", rl, 3);
        chk("w3_no_wr", wl, 0);
        chk("w3_rd_data", {16'd0, rd}, 32'hC3C3);
        mem3[8'h41] = 16'h3C3C;
        xfer(1, 0, 0, 18'h00041, 16'h0, 2, e, wl, rl, ok, rd);
        chk("w3_drop_latency", e, 5);
        chk("w3_drop_data", {16'd0, rd}, 32'h3C3C);
        xfer(1, 0, 1, 18'h00042, 16'h1357, 99, e, wl, rl, ok, rd);
        chk("w3_wr_strobe", wl, 3);
        chk("w3_wr_bus", {31'd0, ok}, 1);
        chk("w3_wr_mem", {16'd0, mem3[8'h42]}, 32'h1357);
        repeat (6) @(negedge clk);
        chk("w3_idle_after", {31'd0, ce3}, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
